// File: rtl/stream_pack_fifo.sv
// Packs an 8-bit byte stream little-endian into 32-bit words and queues them
// in a first-word-fall-through FIFO with a valid/ready drain and a drop counter.
module stream_pack_fifo #(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [2:0]    out_bytes,
    output logic          full,
    output logic [LW-1:0] level,
    output logic [7:0]    drop_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pack_q, pack_d;
    logic [1:0]    pc_q, pc_d;
    logic [31:0]   mem_data_q  [DEPTH];
    logic [2:0]    mem_bytes_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic        complete, pop, push, drop, full_w;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        word_data  = pack_q;
        word_bytes = {1'b0, pc_q} + {2'b00, in_valid};
        pack_d     = pack_q;
        pc_d       = pc_q;
        if (in_valid) begin
            word_data[{pc_q, 3'b000} +: 8] = in_data;
        end
        complete = (in_valid && (pc_q == 2'd3)) || (flush && ((pc_q != 2'd0) || in_valid));
        if (complete) begin
            // The pack register is cleared even when the word is dropped.
            pack_d = '0;
            pc_d   = '0;
        end else if (in_valid) begin
            pack_d = word_data;
            pc_d   = pc_q + 2'd1;
        end
    end

    always_comb begin
        full_w     = (level_q == LW'(DEPTH));
        pop        = (level_q != '0) && out_ready;
        push       = complete && (!full_w || pop);
        drop       = complete && full_w && !pop;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q     <= '0;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            // NOTE: storage is a register array, so it can be cleared in reset;
            // a RAM macro could not be, and reads would then need masking.
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i]  <= '0;
                mem_bytes_q[i] <= '0;
            end
        end else begin
            pack_q     <= pack_d;
            pc_q       <= pc_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) begin
                mem_data_q[wr_ptr_q]  <= word_data;
                mem_bytes_q[wr_ptr_q] <= word_bytes;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Popped entries keep stale data, so the head is masked while empty.
    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_data_q[rd_ptr_q]  : 32'h0;
    assign out_bytes = out_valid ? mem_bytes_q[rd_ptr_q] : 3'd0;
    assign full      = (level_q == LW'(DEPTH));
    assign level     = level_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
